uart_cmd_decoder: RTL and testbench

//  Downstream of the UART receiver. Collects received bytes into fixed 4-byte command

---
 rtl/uart_cmd_decoder.sv | 135 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Command-frame decoder behind the UART receiver: synchronises RxDone, assembles
// SOF/CMD/ARG/CHK frames, executes motor/light commands and applies the limit interlock.
module uart_cmd_decoder #(
  parameter logic [7:0] SOF         = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         CNT_W       = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       RxDone,
  input  logic [7:0] RxData,
  input  logic       limit1,
  input  logic       limit2,
  output logic [1:0] motor_cmd,
  output logic       light_cmd,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic [7:0] last_cmd,
  output logic       busy
);

  // state   | meaning
  // IDLE    | waiting for SOF, other bytes dropped silently
  // GET_CMD | expecting CMD byte
  // GET_ARG | expecting ARG byte
  // GET_CHK | expecting CHK byte, checksum decided here
  // EXEC    | apply known command or divert to ERR
  // ERR     | report error, bump saturating counter
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GET_CMD = 3'd1;
  localparam logic [2:0] S_GET_ARG = 3'd2;
  localparam logic [2:0] S_GET_CHK = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

  logic [2:0]       state;
  logic             sync0, sync1, sync2;
  logic             byte_stb;
  logic [CNT_W-1:0] to_cnt;
  logic [7:0]       cmd_q;
  logic [7:0]       arg_q;
  logic             known_cmd;
  logic             limit_any;

  assign known_cmd = (cmd_q == 8'h10) || (cmd_q == 8'h20) || (cmd_q == 8'h30);
  assign limit_any = limit1 | limit2;
  assign busy      = (state != S_IDLE);

  // Strobe is registered so it lands on the third edge after RxDone rises.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync0    <= 1'b0;
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      byte_stb <= 1'b0;
    end else begin
      sync0    <= RxDone;
      sync1    <= sync0;
      sync2    <= sync1;
      byte_stb <= sync1 & ~sync2;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      to_cnt    <= '0;
      cmd_q     <= 8'h00;
      arg_q     <= 8'h00;
      motor_cmd <= 2'b00;
      light_cmd <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= 8'h00;
      last_cmd  <= 8'h00;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          to_cnt <= '0;
          if (byte_stb && RxData == SOF) state <= S_GET_CMD;
        end
        S_GET_CMD, S_GET_ARG, S_GET_CHK: begin
          if (byte_stb) begin
            to_cnt <= '0;
            if (state == S_GET_CMD) begin
              cmd_q <= RxData;
              state <= S_GET_ARG;
            end else if (state == S_GET_ARG) begin
              arg_q <= RxData;
              state <= S_GET_CHK;
            end else begin
              state <= (RxData == (cmd_q ^ arg_q)) ? S_EXEC : S_ERR;
            end
          end else if (to_cnt == TO_LIM) begin
            to_cnt <= '0;
            state  <= S_ERR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (known_cmd) begin
            case (cmd_q)
              8'h10:   motor_cmd <= arg_q[1:0];
              8'h20:   light_cmd <= arg_q[0];
              default: begin
                motor_cmd <= 2'b00;
                light_cmd <= 1'b0;
              end
            endcase
            frame_ok <= 1'b1;
            last_cmd <= cmd_q;
            state    <= S_IDLE;
          end else begin
            state <= S_ERR;
          end
        end
        S_ERR: begin
          frame_err <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'h01;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Interlock has the last word, even over a motor command executing this cycle.
      if (limit_any) motor_cmd <= 2'b00;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: a frame-level model predicts each ok/err pulse,
// a monitor compares every pulse the DUT raises against the queued prediction.
module tb_uart_cmd_decoder;

  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       limit1 = 1'b0;
  logic       limit2 = 1'b0;
  logic [1:0] motor_cmd;
  logic       light_cmd;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_count;
  logic [7:0] last_cmd;
  logic       busy;

  uart_cmd_decoder #(.SOF(8'hA5), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
    .Clk(clk), .Rst_n(rst_n), .RxDone(rx_done), .RxData(rx_data),
    .limit1(limit1), .limit2(limit2), .motor_cmd(motor_cmd), .light_cmd(light_cmd),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_count(err_count),
    .last_cmd(last_cmd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [1:0] motor;
    logic       light;
    logic [7:0] last;
    logic [7:0] errc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: frame-level view of the protocol
  logic [7:0] fb[$];
  bit         in_frame = 0;
  bit         m_lim = 0;
  logic [1:0] m_motor = 0;
  logic       m_light = 0;
  logic [7:0] m_last = 0;
  int         m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic is_err);
    exp_t e;
    e.is_err = is_err;
    e.motor  = m_motor;
    e.light  = m_light;
    e.last   = m_last;
    e.errc   = 8'(m_err);
    exp_q.push_back(e);
  endfunction

  function automatic void model_err();
    if (m_err < 255) m_err++;
    push_exp(1'b1);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] c, a, k;
    if (!in_frame) begin
      if (b == 8'hA5) begin
        in_frame = 1;
        fb.delete();
      end
    end else begin
      fb.push_back(b);
      if (fb.size() == 3) begin
        in_frame = 0;
        c = fb[0]; a = fb[1]; k = fb[2];
        if (k != (c ^ a) || !(c == 8'h10 || c == 8'h20 || c == 8'h30)) begin
          model_err();
        end else begin
          if (c == 8'h10) m_motor = m_lim ? 2'b00 : a[1:0];
          else if (c == 8'h20) m_light = a[0];
          else begin m_motor = 2'b00; m_light = 1'b0; end
          m_last = c;
          push_exp(1'b0);
        end
      end
    end
  endfunction

  function automatic void model_timeout();
    if (in_frame) begin
      in_frame = 0;
      model_err();
    end
  endfunction

  function automatic void model_reset();
    in_frame = 0; fb.delete();
    m_motor = 0; m_light = 0; m_last = 0; m_err = 0;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (frame_ok || frame_err)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got ok=%0d err=%0d expected no pulse at %0t",
                 frame_ok, frame_err, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_is_err", frame_err, mon_e.is_err);
        check("pulse_is_ok", frame_ok, !mon_e.is_err);
        check("motor_cmd", motor_cmd, mon_e.motor);
        check("light_cmd", light_cmd, mon_e.light);
        check("last_cmd", last_cmd, mon_e.last);
        check("err_count", err_count, mon_e.errc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    repeat (4) @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(a);
    send_byte(k);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic limit_pulse(input bit which, input int len);
    @(negedge clk);
    if (which) limit2 = 1'b1; else limit1 = 1'b1;
    m_motor = 2'b00;
    @(negedge clk);
    check("interlock_next_edge", motor_cmd, 2'b00);
    repeat (len) @(negedge clk);
    limit1 = 1'b0;
    limit2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_timeout(input int extra);
    send_byte(8'hA5);
    for (int i = 0; i < extra; i++) send_byte(8'($urandom));
    model_timeout();
    repeat (TO + 20) @(negedge clk);
    drain();
    check("busy_after_timeout", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] c, a, k;
    int r;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_motor", motor_cmd, 0);
    check("rst_light", light_cmd, 0);
    check("rst_err_count", err_count, 0);
    check("rst_last_cmd", last_cmd, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);

    // T1 valid motor frame
    send_frame(8'h10, 8'h03, 8'h13);
    drain();
    check("t1_motor", motor_cmd, 2'b11);

    // T4 interlock and re-enable
    limit_pulse(1'b0, 3);
    repeat (5) @(negedge clk);
    check("t4_motor_stays_0", motor_cmd, 2'b00);
    send_frame(8'h10, 8'h02, 8'h12);
    drain();
    check("t4_motor_reenabled", motor_cmd, 2'b10);

    // T2 bad checksum
    send_frame(8'h20, 8'h01, 8'h20);
    drain();
    check("t2_light_stays_0", light_cmd, 1'b0);

    // T3 timeout then good light frame
    do_timeout(1);
    send_frame(8'h20, 8'h01, 8'h21);
    drain();
    check("t3_light_on", light_cmd, 1'b1);

    // held RxDone yields one strobe only
    model_byte(8'hA5);
    @(negedge clk);
    rx_data = 8'hA5;
    rx_done = 1'b1;
    repeat (100) @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_busy", busy, 1'b1);
    send_byte(8'h10); send_byte(8'h01); send_byte(8'h11);
    drain();

    // limit held while a motor command executes
    @(negedge clk);
    limit2 = 1'b1; m_lim = 1; m_motor = 2'b00;
    send_frame(8'h10, 8'h03, 8'h13);
    drain();
    limit2 = 1'b0; m_lim = 0;
    @(negedge clk);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: begin
          case ($urandom_range(0, 2))
            0: c = 8'h10;
            1: c = 8'h20;
            default: c = 8'h30;
          endcase
          a = 8'($urandom);
          send_frame(c, a, c ^ a);
        end
        4: begin
          c = 8'h20; a = 8'($urandom);
          k = c ^ a ^ 8'($urandom_range(1, 255));
          send_frame(c, a, k);
        end
        5: begin
          c = 8'($urandom);
          if (c == 8'h10 || c == 8'h20 || c == 8'h30) c = c ^ 8'h01;
          a = 8'($urandom);
          send_frame(c, a, c ^ a);
        end
        6: begin
          k = 8'($urandom);
          if (k == 8'hA5) k = 8'h5A;
          send_byte(k);
        end
        7: do_timeout($urandom_range(0, 2));
        8: limit_pulse(1'($urandom), $urandom_range(1, 5));
        default: begin
          @(negedge clk);
          limit1 = 1'b1; m_lim = 1; m_motor = 2'b00;
          a = 8'($urandom);
          send_frame(8'h10, a, 8'h10 ^ a);
          limit1 = 1'b0; m_lim = 0;
        end
      endcase
      drain();
    end

    // T5 garbage in IDLE, then saturate the error counter
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    drain();
    for (int i = 0; i < 256; i++) send_frame(8'h20, 8'h01, 8'h00);
    drain();
    check("t5_err_sat", err_count, 8'hFF);
    send_frame(8'h30, 8'h00, 8'h31);
    drain();
    check("t5_err_holds", err_count, 8'hFF);

    // T6 reset in GET_ARG
    send_byte(8'hA5);
    send_byte(8'h20);
    check("t6_busy_in_frame", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_motor", motor_cmd, 0);
    check("t6_rst_light", light_cmd, 0);
    check("t6_rst_err_count", err_count, 0);
    check("t6_rst_last_cmd", last_cmd, 0);
    check("t6_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_idle_after_rst", busy, 0);
    send_frame(8'h20, 8'h01, 8'h21);
    drain();
    check("t6_light_after_rst", light_cmd, 1'b1);
    check("t6_errc_after_rst", err_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
